// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state codes, access sizes and RV32I load/store funct3 values for the load/store unit
package lsu_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] = 2'b11 has no defined size and is handled as a word
    function automatic size_e size_of(input logic [1:0] f3_lo);
        return f3_lo == 2'b00 ? SZ_BYTE : f3_lo == 2'b01 ? SZ_HALF : SZ_WORD;
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half lane of a read word and sign/zero-extends it
//   rdata  : word returned by data memory
//   offset : byte offset of the access, already truncated to the access size
//   funct3 : RV32I load funct3 (size in [1:0], zero-extend in [2])
//   data   : 32-bit writeback value
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    size_e       sz;
    logic [31:0] sh;
    logic        ext;

    assign sz   = size_of(funct3[1:0]);
    assign sh   = rdata >> {offset, 3'b000};
    assign ext  = ~funct3[2] & (sz == SZ_BYTE ? sh[7] : sh[15]);
    assign data = sz == SZ_BYTE ? {{24{ext}}, sh[7:0]} :
                  sz == SZ_HALF ? {{16{ext}}, sh[15:0]} : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: serialised single-outstanding load/store stage between execute and writeback
//   in_*   : operation from execute (accepted only in IDLE, in_ready high)
//   mem_*  : registered data-memory request port, held stable until mem_gnt
//   out_*  : one-cycle completion pulse with rd tag, extended load data and fault flag
//   Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of truncating their address.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [4:0]        in_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic [4:0]        out_rd,
    output logic [31:0]       out_data,
    output logic              out_fault
);
    logic [1:0]  state;
    logic [2:0]  f3;
    logic [1:0]  off;
    size_e       sz;
    logic [1:0]  eff_off;
    logic [3:0]  strb;
    logic [31:0] wdat;
    logic [31:0] ld_data;
    logic        trap;

    assign sz        = size_of(in_funct3[1:0]);
    // Misaligned low address bits are dropped so the access stays inside its natural lane.
    assign eff_off   = sz == SZ_WORD ? 2'b00 : sz == SZ_HALF ? {in_addr[1], 1'b0} : in_addr[1:0];
    assign strb      = sz == SZ_BYTE ? 4'b0001 << eff_off : sz == SZ_HALF ? 4'b0011 << eff_off : 4'b1111;
    assign wdat      = sz == SZ_BYTE ? {4{in_wdata[7:0]}} : sz == SZ_HALF ? {2{in_wdata[15:0]}} : in_wdata;
    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_DONE;

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_q;
    assign trap      = (sz == SZ_HALF && in_addr[0]) || (sz == SZ_WORD && in_addr[1:0] != 2'b00);
    assign out_fault = fault_q && state == S_DONE;
    always_ff @(posedge clk) begin
        fault_q <= reset ? 1'b0 : state == S_IDLE ? in_valid && trap : fault_q;
    end
`else
    assign trap      = 1'b0;
    assign out_fault = 1'b0;
`endif

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .offset (off),
        .funct3 (f3),
        .data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'h0;
            out_rd    <= 5'd0;
            out_data  <= 32'h0;
            f3        <= 3'b000;
            off       <= 2'b00;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    f3        <= in_funct3;
                    off       <= eff_off;
                    out_rd    <= in_load ? in_rd : 5'd0;
                    out_data  <= 32'h0;
                    mem_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                    mem_we    <= in_store && !trap;
                    mem_wstrb <= in_store && !trap ? strb : 4'b0000;
                    mem_wdata <= in_store ? wdat : 32'h0;
                    mem_req   <= !trap;
                    state     <= trap ? S_DONE : S_REQ;
                end
                // mem_we still identifies a store here; it is cleared with the grant
                S_REQ: if (mem_gnt) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= 4'b0000;
                    state     <= mem_we ? S_DONE : S_WAIT;
                end
                S_WAIT: if (mem_rvalid) begin
                    out_data <= ld_data;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomised load/store checks against a byte-level reference model
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_load = 1'b0, in_store = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_addr = 32'h0, in_wdata = 32'h0;
    logic [4:0]  in_rd = 5'd0;
    logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;
    logic [3:0]  mem_wstrb;
    logic        out_valid, out_fault;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    int          n_pass = 0, n_total = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .out_valid(out_valid), .out_rd(out_rd),
        .out_data(out_data), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rw);
        int n = size_bytes(f3);
        int o = (a % 4) / n * n;
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        logic [63:0] v = ({32'h0, rw} >> (8 * o)) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        int n = size_bytes(f3);
        int o = (a % 4) / n * n;
        logic [7:0] s = ((8'd1 << n) - 8'd1) << o;
        return s[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = size_bytes(f3);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    // gd = grant hold-off cycles, rv = WAIT cycle in which rvalid arrives (1 = first)
    task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input int gd, input int rv, input logic [31:0] rw);
        logic trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (a % size_bytes(f3)) != 0;
`endif
        chk("ready_before", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_load = ld; in_store = !ld; in_funct3 = f3; in_addr = a; in_wdata = wd; in_rd = rd;
        @(negedge clk);
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_addr = $urandom; in_wdata = $urandom;
        if (!trap) begin
            for (int k = 0; k <= gd; k++) begin
                chk("req", {31'b0, mem_req}, 32'd1);
                chk("we", {31'b0, mem_we}, {31'b0, !ld});
                chk("addr", mem_addr, a & ~32'h3);
                chk("strb", {28'b0, mem_wstrb}, ld ? 32'h0 : {28'b0, model_strb(f3, a)});
                if (!ld) chk("wdata", mem_wdata, model_wdata(f3, wd));
                chk("busy_ready", {31'b0, in_ready}, 32'd0);
                chk("early_valid", {31'b0, out_valid}, 32'd0);
                if (k < gd) begin
                    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
                end else begin
                    mem_gnt = 1'b1; mem_rvalid = 1'b0;
                end
                @(negedge clk);
            end
            mem_gnt = 1'b0;
            chk("req_drop", {31'b0, mem_req}, 32'd0);
            if (ld) begin
                for (int k = 1; k < rv; k++) begin
                    chk("wait_valid", {31'b0, out_valid}, 32'd0);
                    @(negedge clk);
                end
                mem_rvalid = 1'b1; mem_rdata = rw;
                @(negedge clk);
                mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
        end
        chk("out_valid", {31'b0, out_valid}, 32'd1);
        chk("out_rd", {27'b0, out_rd}, ld && !trap ? {27'b0, rd} : (ld ? {27'b0, rd} : 32'h0));
        chk("out_data", out_data, ld && !trap ? model_load(f3, a, rw) : 32'h0);
        chk("out_fault", {31'b0, out_fault}, {31'b0, trap});
        chk("done_req", {31'b0, mem_req}, 32'd0);
        chk("done_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("pulse_end", {31'b0, out_valid}, 32'd0);
        chk("ready_after", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0] ld_f3 [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_strb", {28'b0, mem_wstrb}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_fault", {31'b0, out_fault}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_rd", {27'b0, out_rd}, 32'd0);
        run_op(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd7, 0, 1, 32'h0);
        run_op(1'b0, 3'b000, 32'h103, 32'h000000A5, 5'd3, 0, 1, 32'h0);
        run_op(1'b1, 3'b000, 32'h102, 32'h0, 5'd9, 0, 1, 32'h12F03456);
        run_op(1'b1, 3'b100, 32'h102, 32'h0, 5'd10, 0, 1, 32'h12F03456);
        run_op(1'b1, 3'b001, 32'h202, 32'h0, 5'd11, 3, 2, 32'h80010000);
        run_op(1'b1, 3'b010, 32'h101, 32'h0, 5'd12, 0, 1, 32'hCAFEF00D);
        run_op(1'b0, 3'b001, 32'h305, 32'h1234ABCD, 5'd1, 1, 1, 32'h0);
        for (int i = 0; i < 40; i++) begin
            logic ld = 1'($urandom);
            run_op(ld, ld ? ld_f3[$urandom_range(5)] : st_f3[$urandom_range(2)], $urandom, $urandom,
                   5'($urandom), $urandom_range(3), $urandom_range(1, 3), $urandom);
        end
        in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_addr = 32'h40; in_rd = 5'd5;
        @(negedge clk);
        in_valid = 1'b0; in_load = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late_rvalid", {31'b0, out_valid}, 32'd0);
            chk("late_ready", {31'b0, in_ready}, 32'd1);
            @(negedge clk);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
